// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU engine with HI/LO registers.
// Works on unsigned magnitudes over WIDTH cycles, then fixes signs in one extra cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   d;
    logic [2*WIDTH-1:0] p, p_step, prod_s;
    logic [WIDTH:0]     mul_sum, trial;
    logic [WIDTH-1:0]   ma, mb, q_s, r_s, hi_nx, lo_nx;
    logic               sa, sb, is_div, neg_q, neg_r, accept;

    assign sa     = ~op[0] & rs_val[WIDTH-1];
    assign sb     = ~op[0] & rt_val[WIDTH-1];
    assign ma     = sa ? -rs_val : rs_val;
    assign mb     = sb ? -rt_val : rt_val;
    assign accept = (state == IDLE) && start;
    assign busy   = (state != IDLE);

    // p holds {acc, multiplier} for multiply and {remainder, dividend} for divide
    always_comb begin
        mul_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, d} : '0);
        trial   = p[2*WIDTH-1:WIDTH-1] - {1'b0, d};
        p_step  = is_div ? (trial[WIDTH] ? {p[2*WIDTH-2:0], 1'b0}
                                         : {trial[WIDTH-1:0], p[WIDTH-2:0], 1'b1})
                         : {mul_sum, p[WIDTH-1:1]};
        prod_s  = neg_q ? -p : p;
        q_s     = (d == '0) ? '1 : (neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0]);
        r_s     = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_nx = state;
        hi_nx    = hi;
        lo_nx    = lo;
        case (state)
            IDLE: begin
                state_nx = start ? CALC : IDLE;
                hi_nx    = (!start && hi_we) ? wr_data : hi;
                lo_nx    = (!start && lo_we) ? wr_data : lo;
            end
            CALC: state_nx = (cnt == CW'(WIDTH - 1)) ? FIX : CALC;
            FIX: begin
                state_nx = IDLE;
                hi_nx    = is_div ? r_s : prod_s[2*WIDTH-1:WIDTH];
                lo_nx    = is_div ? q_s : prod_s[WIDTH-1:0];
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            d      <= '0;
            p      <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state <= state_nx;
            done  <= (state == FIX);
            hi    <= hi_nx;
            lo    <= lo_nx;
            if (accept) begin
                cnt    <= '0;
                d      <= mb;
                p      <= {{WIDTH{1'b0}}, ma};
                is_div <= op[1];
                neg_q  <= sa ^ sb;
                neg_r  <= sa;
            end else if (state == CALC) begin
                cnt <= cnt + 1'b1;
                p   <= p_step;
            end
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors for mult_div_unit with hand-computed results.
module tb_mult_div_unit;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        start = 0;
    logic [1:0]  op = 0;
    logic [31:0] rs_val = 0, rt_val = 0, wr_data = 0;
    logic        hi_we = 0, lo_we = 0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int          errors = 0, checks = 0;
    int          n, bad;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs_val(rs_val),
        .rt_val(rt_val), .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o;
        rs_val = a;
        rt_val = b;
        start = 1;
    endtask

    task automatic wait_done(output int cyc, output int nbusy);
        cyc = 0;
        nbusy = 0;
        while (!done && cyc < 40) begin
            if (!busy) nbusy++;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        launch(o, a, b);
        @(posedge clk);
        #1 start = 0;
        wait_done(n, bad);
        chk({tag, "_lat"}, n, 33);
        chk({tag, "_busy"}, bad, 0);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #12 rst_n = 1;
        @(posedge clk);
        #1;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        run("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        @(posedge clk);
        #1 chk("done_pulse", done, 0);
        run("mult_neg",  2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run("mult_min",  2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
        run("div_neg",   2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run("divu",      2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        run("div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        run("divu_zero", 2'b11, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF);
        run("div_zero",  2'b10, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF);

        launch(2'b01, 32'd3, 32'd4);
        @(posedge clk);
        #1 start = 0;
        repeat (10) @(posedge clk);
        #1;
        launch(2'b10, 32'd7, 32'd0);
        hi_we = 1;
        wr_data = 32'h55;
        @(posedge clk);
        #1 start = 0;
        hi_we = 0;
        chk("busy_we_hi", hi, 32'hFFFFFFFB);
        wait_done(n, bad);
        chk("restart_lat", n, 22);
        chk("restart_hi", hi, 0);
        chk("restart_lo", lo, 12);
        @(posedge clk);
        #1 chk("restart_single", done, 0);

        hi_we = 1;
        lo_we = 1;
        wr_data = 32'hA5A5A5A5;
        @(posedge clk);
        #1 hi_we = 0;
        lo_we = 0;
        chk("mt_hi", hi, 32'hA5A5A5A5);
        chk("mt_lo", lo, 32'hA5A5A5A5);

        launch(2'b11, 32'd100, 32'd7);
        hi_we = 1;
        wr_data = 32'hDEADBEEF;
        @(posedge clk);
        #1 start = 0;
        hi_we = 0;
        chk("we_start_hi", hi, 32'hA5A5A5A5);
        chk("we_start_busy", busy, 1);
        wait_done(n, bad);
        chk("we_start_res", hi, 32'd2);

        launch(2'b01, 32'd9, 32'd9);
        @(posedge clk);
        #1 start = 0;
        repeat (5) @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        @(posedge clk);
        #1 rst_n = 1;
        run("post_rst", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
